// File: rtl/sparc_pipe_pkg.sv
// Shared constants and types for the SPARC IF/ID pipeline slice.
// The NOP word is injected on reset and on annul/flush. The reset PC/nPC pair
// is the architectural start point. The slot-state enum is what hazard and
// branch logic observe on ID_state.
package sparc_pipe_pkg;

  // sethi 0, %g0 : canonical SPARC NOP
  localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_NPC = 32'h0000_0004;

  // Slot occupancy. Encoding 3 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    HELD  = 2'd2
  } id_state_t;

  // True for the states in which the slot carries a real instruction.
  function automatic logic state_is_live(input id_state_t s);
    return (s == LIVE) || (s == HELD);
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Single pipeline field register.
// Priority on each edge: async reset value > synchronous clear value > hold > load.
module pipe_field_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field storage: reset, clear to a fixed word, freeze, or capture d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= RST_VAL;
    else if (clr)   q <= CLR_VAL;
    else if (!hold) q <= d;
  end

endmodule

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register for the SPARC datapath.
// It captures PC, nPC and the instruction each clock. It holds them while ID_stall
// is high. When annul_flush is high it squashes the slot to NOP and still passes
// the PC/nPC through, so trap and debug logic keep the PC.
// An occupancy FSM (EMPTY/LIVE/HELD) drives ID_state, and ID_valid follows it.
// Optional macro IF_ID_PERF_EN adds saturating 16-bit squash and stall counters.
module if_id_pipeline_register
  import sparc_pipe_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter logic [DW-1:0] NOP_WORD = DW'(SPARC_NOP)
) (
  input  logic          clk,
  input  logic          system_reset,
  input  logic [AW-1:0] IF_pc,
  input  logic [AW-1:0] IF_npc,
  input  logic [DW-1:0] IF_instr,
  input  logic          IF_valid,
  input  logic          ID_stall,
  input  logic          annul_flush,
  output logic [AW-1:0] ID_pc,
  output logic [AW-1:0] ID_npc,
  output logic [DW-1:0] ID_instr,
  output logic          ID_valid,
  output logic [1:0]    ID_state
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]   perf_squash_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  id_state_t state;

  // A flush must override a stall. PC/nPC therefore see "hold" only when a stall
  // is not cancelled by a flush. The instruction field gets the same effect
  // through its clear input.
  logic addr_hold;
  assign addr_hold = ID_stall && !annul_flush;

  pipe_field_reg #(
    .W       (AW),
    .RST_VAL (AW'(RESET_PC)),
    .CLR_VAL ('0)
  ) u_pc (
    .clk  (clk),
    .rst  (system_reset),
    .clr  (1'b0),
    .hold (addr_hold),
    .d    (IF_pc),
    .q    (ID_pc)
  );

  pipe_field_reg #(
    .W       (AW),
    .RST_VAL (AW'(RESET_NPC)),
    .CLR_VAL ('0)
  ) u_npc (
    .clk  (clk),
    .rst  (system_reset),
    .clr  (1'b0),
    .hold (addr_hold),
    .d    (IF_npc),
    .q    (ID_npc)
  );

  pipe_field_reg #(
    .W       (DW),
    .RST_VAL (NOP_WORD),
    .CLR_VAL (NOP_WORD)
  ) u_instr (
    .clk  (clk),
    .rst  (system_reset),
    .clr  (annul_flush),
    .hold (ID_stall),
    .d    (IF_instr),
    .q    (ID_instr)
  );

  // Occupancy FSM. ID_valid is registered alongside the state so that it always
  // equals "state is LIVE or HELD".
  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      state    <= EMPTY;
      ID_valid <= 1'b0;
    end else if (annul_flush) begin
      state    <= EMPTY;
      ID_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (!ID_stall) begin
            state    <= IF_valid ? LIVE : EMPTY;
            ID_valid <= IF_valid;
          end
        end
        LIVE, HELD: begin
          if (ID_stall) begin
            state    <= HELD;
            ID_valid <= 1'b1;
          end else begin
            state    <= IF_valid ? LIVE : EMPTY;
            ID_valid <= IF_valid;
          end
        end
        default: begin
          state    <= EMPTY;
          ID_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ID_state = state;

`ifdef IF_ID_PERF_EN
  logic squash_sat;
  logic stall_sat;
  assign squash_sat = (perf_squash_cnt == 16'hFFFF);
  assign stall_sat  = (perf_stall_cnt  == 16'hFFFF);

  // Saturating event counters. A stall that a flush cancels counts only as a squash.
  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      perf_squash_cnt <= 16'h0000;
      perf_stall_cnt  <= 16'h0000;
    end else begin
      if (annul_flush && !squash_sat)
        perf_squash_cnt <= perf_squash_cnt + 16'd1;
      if (addr_hold && !stall_sat)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Scoreboard bench for if_id_pipeline_register.
// The driver applies directed vectors on the falling edge and queues the
// hand-computed expected outputs. The monitor pops one entry after each rising edge.
// When IF_ID_PERF_EN is defined, the bench also checks the perf counters.
module tb_if_id_pipeline_register;

  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        system_reset;
  logic [31:0] IF_pc, IF_npc, IF_instr;
  logic        IF_valid, ID_stall, annul_flush;
  logic [31:0] ID_pc, ID_npc, ID_instr;
  logic        ID_valid;
  logic [1:0]  ID_state;
`ifdef IF_ID_PERF_EN
  logic [15:0] perf_squash_cnt, perf_stall_cnt;
`endif

  if_id_pipeline_register dut (
    .clk          (clk),
    .system_reset (system_reset),
    .IF_pc        (IF_pc),
    .IF_npc       (IF_npc),
    .IF_instr     (IF_instr),
    .IF_valid     (IF_valid),
    .ID_stall     (ID_stall),
    .annul_flush  (annul_flush),
    .ID_pc        (ID_pc),
    .ID_npc       (ID_npc),
    .ID_instr     (ID_instr),
    .ID_valid     (ID_valid),
    .ID_state     (ID_state)
`ifdef IF_ID_PERF_EN
    ,
    .perf_squash_cnt (perf_squash_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".pc"},    ID_pc,                e.pc);
    chk({tag, ".npc"},   ID_npc,               e.npc);
    chk({tag, ".instr"}, ID_instr,             e.instr);
    chk({tag, ".valid"}, {31'd0, ID_valid},    {31'd0, e.valid});
    chk({tag, ".state"}, {30'd0, ID_state},    {30'd0, e.st});
  endtask

  // Monitor: compare the registered outputs one step after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk_outputs("vec", exp_q.pop_front());
    end
  end

  // Drive one vector and queue the outputs expected after the next edge.
  task automatic apply(input logic [31:0] pc, npc, instr, input logic v, st, fl,
                       input logic [31:0] epc, enpc, einstr, input logic ev,
                       input logic [1:0] est);
    @(negedge clk);
    IF_pc = pc; IF_npc = npc; IF_instr = instr;
    IF_valid = v; ID_stall = st; annul_flush = fl;
    exp_q.push_back('{pc: epc, npc: enpc, instr: einstr, valid: ev, st: est});
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    IF_pc = '0; IF_npc = '0; IF_instr = '0;
    IF_valid = 1'b0; ID_stall = 1'b0; annul_flush = 1'b0;
    system_reset = 1'b1;
    #2;
    chk_outputs("reset0", '{pc: 32'h0, npc: 32'h4, instr: NOP, valid: 1'b0, st: 2'd0});
    @(negedge clk);
    system_reset = 1'b0;

    // pc, npc, instr, IF_valid, stall, flush -> expected pc, npc, instr, valid, state
    apply(32'h40,  32'h44,  32'h8200_4001, 1, 0, 0, 32'h40,  32'h44,  32'h8200_4001, 1, 2'd1);
    apply(32'h50,  32'h54,  32'h1111_1111, 1, 1, 0, 32'h40,  32'h44,  32'h8200_4001, 1, 2'd2);
    apply(32'h60,  32'h64,  32'h2222_2222, 1, 1, 0, 32'h40,  32'h44,  32'h8200_4001, 1, 2'd2);
    apply(32'h70,  32'h74,  32'h3333_3333, 1, 1, 0, 32'h40,  32'h44,  32'h8200_4001, 1, 2'd2);
    apply(32'h70,  32'h74,  32'h3333_3333, 1, 0, 0, 32'h70,  32'h74,  32'h3333_3333, 1, 2'd1);
    apply(32'h80,  32'h84,  32'h4444_4444, 1, 1, 1, 32'h80,  32'h84,  NOP,           0, 2'd0);
    apply(32'h90,  32'h94,  32'hDEAD_BEEF, 0, 0, 0, 32'h90,  32'h94,  32'hDEAD_BEEF, 0, 2'd0);
    apply(32'hA0,  32'hA4,  32'h5555_5555, 1, 1, 0, 32'h90,  32'h94,  32'hDEAD_BEEF, 0, 2'd0);
    apply(32'hA0,  32'hA4,  32'h5555_5555, 1, 0, 0, 32'hA0,  32'hA4,  32'h5555_5555, 1, 2'd1);
    apply(32'hB0,  32'hB4,  32'h6666_6666, 0, 0, 0, 32'hB0,  32'hB4,  32'h6666_6666, 0, 2'd0);
    apply(32'hC0,  32'hC4,  32'h7777_7777, 1, 0, 0, 32'hC0,  32'hC4,  32'h7777_7777, 1, 2'd1);
    apply(32'hD0,  32'hD4,  32'h8888_8888, 1, 0, 1, 32'hD0,  32'hD4,  NOP,           0, 2'd0);
    apply(32'hE0,  32'hE4,  32'h9999_9999, 1, 0, 0, 32'hE0,  32'hE4,  32'h9999_9999, 1, 2'd1);
    apply(32'hE8,  32'hEC,  32'hCCCC_CCCC, 1, 1, 0, 32'hE0,  32'hE4,  32'h9999_9999, 1, 2'd2);
    apply(32'hF0,  32'hF4,  32'hAAAA_AAAA, 1, 0, 1, 32'hF0,  32'hF4,  NOP,           0, 2'd0);
    apply(32'h100, 32'h104, 32'hBBBB_BBBB, 1, 0, 0, 32'h100, 32'h104, 32'hBBBB_BBBB, 1, 2'd1);
    apply(32'h110, 32'h114, 32'hEEEE_EEEE, 1, 1, 0, 32'h100, 32'h104, 32'hBBBB_BBBB, 1, 2'd2);
    drain();

    // Async reset in the middle of a stall, with no clock edge between assert and check.
    @(posedge clk);
    #3;
    system_reset = 1'b1;
    #1;
    chk_outputs("reset_mid", '{pc: 32'h0, npc: 32'h4, instr: NOP, valid: 1'b0, st: 2'd0});
    @(negedge clk);
    ID_stall = 1'b0;
    system_reset = 1'b0;

`ifdef IF_ID_PERF_EN
    chk("perf_squash_rst", {16'd0, perf_squash_cnt}, 32'd0);
    chk("perf_stall_rst",  {16'd0, perf_stall_cnt},  32'd0);
    for (int k = 1; k <= 5; k++)
      apply(32'(k), 32'(k + 4), 32'h1234_0000, 1, 0, 1, 32'(k), 32'(k + 4), NOP, 0, 2'd0);
    for (int k = 0; k < 7; k++)
      apply(32'h999, 32'h99D, 32'h4321_0000, 1, 1, 0, 32'h5, 32'h9, NOP, 0, 2'd0);
    drain();
    chk("perf_squash_5", {16'd0, perf_squash_cnt}, 32'd5);
    chk("perf_stall_7",  {16'd0, perf_stall_cnt},  32'd7);
    @(negedge clk);
    ID_stall = 1'b1; annul_flush = 1'b0;
    for (int k = 0; k < 65540; k++) @(negedge clk);
    chk("perf_stall_sat",   {16'd0, perf_stall_cnt},  32'h0000_FFFF);
    chk("perf_squash_keep", {16'd0, perf_squash_cnt}, 32'd5);
    ID_stall = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
